qea_state_readout: RTL and testbench

- Hardware reader for the QEA state RAM. After a QEA run completes, it sweeps every state row, captures the PE_NUM packed complex amplitudes in each row, and streams them one amplitude per beat on a valid/ready interface. The stream goes to the host or result FIFO.
- It replaces bench-driven readback. It sits beside QEA and owns the state RAM port A while o_busy is high; the external port-A mux selects on o_busy.

---
 rtl/qea_pkg.sv | 45 ++++
 rtl/qea_state_readout_if.sv | 23 ++
 rtl/qea_row_serializer.sv | 41 ++++
 rtl/qea_state_readout.sv | 120 ++++++++++++
 tb/tb_qea_state_readout.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/qea_pkg.sv
// Shared definitions for the QEA state readout block: geometry, amplitude
// field layout, readout FSM encoding and the qubit-count helpers.
package qea_pkg;

    localparam int PE_NUM_WIDTH           = 2;
    localparam int PE_NUM                 = 1 << PE_NUM_WIDTH;
    localparam int DATA_WIDTH             = 32;
    localparam int STATE_DATA_WIDTH       = DATA_WIDTH * 2;
    localparam int STATE_ADDR_WIDTH       = 16;
    localparam int MAX_QBIT_WIDTH         = 6;
    localparam int DEFAULT_RAM_RD_LATENCY = 1;

    localparam int ROW_WIDTH       = PE_NUM * STATE_DATA_WIDTH;
    localparam int AMP_INDEX_WIDTH = STATE_ADDR_WIDTH + PE_NUM_WIDTH;

    // Complex amplitude layout {real, imag}, each Q2.30.
    localparam int REAL_MSB     = 63;
    localparam int REAL_LSB     = 32;
    localparam int IMAG_MSB     = 31;
    localparam int NUM_FRAC_BIT = 30;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // A qubit count is usable when it fills at least one row and the row
    // count still fits the state RAM address range.
    function automatic logic q_in_range(input logic [MAX_QBIT_WIDTH-1:0] q);
        return (q >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) &&
               ((q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) <= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH));
    endfunction

    // Index of the final row, ROWS-1 = 2^(q-PE_NUM_WIDTH) - 1. A shift of
    // STATE_ADDR_WIDTH pushes every one out, giving an all-ones result.
    function automatic logic [STATE_ADDR_WIDTH-1:0] last_row_of(input logic [MAX_QBIT_WIDTH-1:0] q);
        logic [MAX_QBIT_WIDTH-1:0] shift;
        shift = q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
        return ~({STATE_ADDR_WIDTH{1'b1}} << shift);
    endfunction

endpackage

// File: rtl/qea_state_readout_if.sv
// Amplitude stream interface. valid/ready: a beat transfers on a rising
// clock edge where valid and ready are both high; once valid is raised the
// master holds valid, data, index and last unchanged until that transfer.
interface qea_state_readout_if;
    import qea_pkg::*;

    logic                          amp_valid;
    logic                          amp_ready;
    logic [STATE_DATA_WIDTH-1:0]   amp_data;
    logic [AMP_INDEX_WIDTH-1:0]    amp_index;
    logic                          amp_last;

    modport master (
        output amp_valid, amp_data, amp_index, amp_last,
        input  amp_ready
    );

    modport slave (
        input  amp_valid, amp_data, amp_index, amp_last,
        output amp_ready
    );

endinterface

// File: rtl/qea_row_serializer.sv
// Holds one captured state RAM row and presents its amplitudes one at a
// time, most significant slice first, advancing only on a handshake.
module qea_row_serializer
    import qea_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [ROW_WIDTH-1:0]        row_data,
    input  logic                        send,
    input  logic                        ready,
    output logic [STATE_DATA_WIDTH-1:0] data,
    output logic [PE_NUM_WIDTH-1:0]     beat,
    output logic                        row_end
);

    logic [ROW_WIDTH-1:0]        row_buf;
    logic [STATE_DATA_WIDTH-1:0] slices [PE_NUM];

    for (genvar k = 0; k < PE_NUM; k++) begin : g_slice
        assign slices[k] = row_buf[k*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
    end

    // Row buffer and beat counter; both hold while a beat is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_buf <= '0;
            beat    <= '0;
        end else if (load) begin
            row_buf <= row_data;
            beat    <= '0;
        end else if (send && ready) begin
            beat <= beat + PE_NUM_WIDTH'(1);
        end
    end

    // PE_NUM is a power of two, so PE_NUM-1-beat is simply ~beat.
    assign data    = slices[~beat];
    assign row_end = send && ready && (beat == PE_NUM_WIDTH'(PE_NUM - 1));

endmodule

// File: rtl/qea_state_readout.sv
// Sweeps the QEA state RAM after a run and streams every complex amplitude
// in basis-state order. Owns state RAM port A whenever o_busy is high.
module qea_state_readout
    import qea_pkg::*;
#(
    parameter int RAM_RD_LATENCY = DEFAULT_RAM_RD_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]   i_qbit_num,
    output logic                        o_state_ena,
    output logic [STATE_ADDR_WIDTH-1:0] o_state_addra,
    input  logic [ROW_WIDTH-1:0]        i_state_dout,
    qea_state_readout_if.master         amp,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    output state_t                      dbg_state
);

    state_t                      state, next_state;
    logic [STATE_ADDR_WIDTH-1:0] row, last_row;
    logic [1:0]                  wait_cnt;
    logic                        err_pulse;
    logic                        start_ok, start_bad;
    logic                        wait_last, capture, is_last_row;
    logic                        sending;
    logic [STATE_DATA_WIDTH-1:0] ser_data;
    logic [PE_NUM_WIDTH-1:0]     beat;
    logic                        row_end;

    // Starts are only considered in IDLE; anything else is ignored silently.
    assign start_ok    = i_start && (state == ST_IDLE) && q_in_range(i_qbit_num);
    assign start_bad   = i_start && (state == ST_IDLE) && !q_in_range(i_qbit_num);
    assign wait_last   = (wait_cnt == 2'(RAM_RD_LATENCY - 1));
    assign capture     = (state == ST_WAIT) && wait_last;
    assign is_last_row = (row == last_row);
    assign sending     = (state == ST_SEND);
    assign dbg_state   = state;

    qea_row_serializer u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (capture),
        .row_data (i_state_dout),
        .send     (sending),
        .ready    (amp.amp_ready),
        .data     (ser_data),
        .beat     (beat),
        .row_end  (row_end)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // FSM next-state: one read, the RAM latency wait, then the row's beats.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_ok) next_state = ST_RD;
            ST_RD:   next_state = ST_WAIT;
            ST_WAIT: if (wait_last) next_state = ST_SEND;
            ST_SEND: if (row_end) next_state = is_last_row ? ST_DONE : ST_RD;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Row counter, latched row bound, wait counter and reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            last_row  <= '0;
            wait_cnt  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= start_bad;
            if (start_ok) begin
                row      <= '0;
                last_row <= last_row_of(i_qbit_num);
            end else if (row_end && !is_last_row) begin
                row <= row + STATE_ADDR_WIDTH'(1);
            end
            if (state == ST_WAIT && !wait_last) wait_cnt <= wait_cnt + 2'd1;
            else                                wait_cnt <= 2'd0;
        end
    end

    // FSM outputs; stream fields are forced to zero outside SEND.
    always_comb begin
        o_state_ena   = 1'b0;
        o_state_addra = '0;
        o_done        = 1'b0;
        o_err         = err_pulse;
        o_busy        = (state == ST_RD) || (state == ST_WAIT) || (state == ST_SEND);
        amp.amp_valid = 1'b0;
        amp.amp_data  = '0;
        amp.amp_index = '0;
        amp.amp_last  = 1'b0;
        case (state)
            ST_RD: begin
                o_state_ena   = 1'b1;
                o_state_addra = row;
            end
            ST_SEND: begin
                amp.amp_valid = 1'b1;
                amp.amp_data  = ser_data;
                amp.amp_index = {row, beat};
                amp.amp_last  = is_last_row && (beat == PE_NUM_WIDTH'(PE_NUM - 1));
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qea_state_readout.sv
// Directed/randomized bench for qea_state_readout with a row-level model.
module tb_qea_state_readout;
    import qea_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic [MAX_QBIT_WIDTH-1:0]   qbit_num;
    logic                        state_ena;
    logic [STATE_ADDR_WIDTH-1:0] state_addra;
    logic [ROW_WIDTH-1:0]        state_dout;
    logic                        busy, done, err, ready;
    state_t                      dbg_state;

    int checks = 0;
    int errors = 0;

    logic [ROW_WIDTH-1:0]        mem [256];
    logic [STATE_DATA_WIDTH-1:0] exp_q [$];
    int                          exp_idx_q [$];
    bit                          exp_last_q [$];

    qea_state_readout_if amp ();
    assign amp.amp_ready = ready;

    qea_state_readout dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_qbit_num    (qbit_num),
        .o_state_ena   (state_ena),
        .o_state_addra (state_addra),
        .i_state_dout  (state_dout),
        .amp           (amp),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .dbg_state     (dbg_state)
    );

    // clock and state RAM model (one-cycle read latency)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (state_ena) state_dout <= mem[state_addra[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Row r, beat k carries basis index r*4+k in the real field, its inverse in imag.
    task automatic fill_pattern();
        for (int r = 0; r < 256; r++) begin
            for (int k = 0; k < PE_NUM; k++) begin
                logic [31:0] v;
                v = 32'(r * PE_NUM + (PE_NUM - 1 - k));
                mem[r][k*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = {v, ~v};
            end
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < 256; r++)
            for (int w = 0; w < ROW_WIDTH / 32; w++)
                mem[r][w*32 +: 32] = $urandom;
    endtask

    // ready_mode: 0 always high, 1 high one cycle in three, 2 random.
    task automatic run_stream(input int q, input int ready_mode, input int exp_done,
                              input int abort_beat, input int inject_beat);
        int rows, n, beats;
        bit done_seen, stalled, err_seen, aborted, injected;
        logic [STATE_DATA_WIDTH-1:0] held_data;
        logic [AMP_INDEX_WIDTH+1:0]  held_ctrl;
        rows = 1 << (q - PE_NUM_WIDTH);
        exp_q.delete(); exp_idx_q.delete(); exp_last_q.delete();
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < PE_NUM; b++) begin
                exp_q.push_back(mem[r][(PE_NUM - 1 - b)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH]);
                exp_idx_q.push_back(r * PE_NUM + b);
                exp_last_q.push_back(r == rows - 1 && b == PE_NUM - 1);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; qbit_num = MAX_QBIT_WIDTH'(q); ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", busy, 1);
        n = 0; beats = 0; done_seen = 0; stalled = 0; err_seen = 0; aborted = 0; injected = 0;
        held_data = '0; held_ctrl = '0;
        while (!done_seen && !aborted && n < 3000) begin
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = (n % 3 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            start = 1'b0;
            if (inject_beat >= 0 && beats == inject_beat && !injected) begin
                start = 1'b1; qbit_num = 6'd20; injected = 1;
            end
            #1;
            if (err) err_seen = 1;
            if (done) begin
                done_seen = 1;
                if (exp_done >= 0) check("done_cycle", 64'(n), 64'(exp_done));
                check("busy_in_done", busy, 0);
            end
            if (stalled) begin
                check("stall_data", amp.amp_data, held_data);
                check("stall_ctrl", {amp.amp_valid, amp.amp_index, amp.amp_last}, held_ctrl);
            end
            stalled = 0;
            if (amp.amp_valid) begin
                if (abort_beat >= 0 && beats == abort_beat) begin
                    rst = 1'b1; aborted = 1;
                end else if (ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        check("beat_data", amp.amp_data, exp_q.pop_front());
                        check("beat_index", 64'(amp.amp_index), 64'(exp_idx_q.pop_front()));
                        check("beat_last", amp.amp_last, exp_last_q.pop_front());
                    end
                    beats++;
                end else begin
                    stalled   = 1;
                    held_data = amp.amp_data;
                    held_ctrl = {1'b1, amp.amp_index, amp.amp_last};
                end
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (aborted) begin
            check("abort_outputs", {amp.amp_valid, amp.amp_last, busy, done, err, state_ena}, 0);
            check("abort_data", amp.amp_data, 0);
            check("abort_index_addr", {amp.amp_index, state_addra}, 0);
            rst = 1'b0;
        end else begin
            check("done_seen", done_seen, 1);
            check("beats_total", 64'(beats), 64'(rows * PE_NUM));
            check("no_err_in_run", err_seen, 0);
            check("idle_after_done", {busy, done, amp.amp_valid}, 0);
        end
    endtask

    task automatic run_reject(input int q);
        int bad;
        @(posedge clk); #1;
        start = 1'b1; qbit_num = MAX_QBIT_WIDTH'(q);
        @(posedge clk); #1;
        start = 1'b0;
        check("reject_err", err, 1);
        check("reject_busy", busy, 0);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (err || busy || state_ena || amp.amp_valid || done) bad++;
        end
        check("reject_quiet", 64'(bad), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; qbit_num = '0; ready = 1'b0;
        state_dout = '0;
        fill_pattern();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {amp.amp_valid, amp.amp_last, busy, done, err, state_ena}, 0);
        check("reset_data", amp.amp_data, 0);
        check("reset_index_addr", {amp.amp_index, state_addra}, 0);
        check("reset_state", dbg_state, ST_IDLE);
        rst = 1'b0;

        // full sweep, ready held high, index pattern
        run_stream(7, 0, 192, -1, -1);

        // single unit amplitude at basis state 0
        for (int r = 0; r < 256; r++) mem[r] = '0;
        mem[0][ROW_WIDTH-1 -: STATE_DATA_WIDTH] = 64'h4000_0000_0000_0000;
        run_stream(7, 0, 192, -1, -1);

        // same index pattern under one-in-three backpressure
        fill_pattern();
        run_stream(7, 1, -1, -1, -1);

        // out-of-range qubit counts
        run_reject(1);
        run_reject(20);

        // single row with a start pulsed mid-stream
        fill_random();
        run_stream(2, 0, 6, -1, 1);

        // reset during beat 50, then a fresh q=3 readout
        run_stream(7, 0, -1, 50, -1);
        fill_random();
        run_stream(3, 2, -1, -1, -1);

        // random data and random backpressure
        fill_random();
        run_stream(5, 2, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
